// File: rtl/ekf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ekf_pkg
// Purpose  : Shared stage codes, PE_config status codes, error codes and the
//            scheduler state encoding for the EKF stage sequencer.
// Revision : 1.0  initial release
// ============================================================================
package ekf_pkg;

    localparam logic [2:0] STAGE_IDLE  = 3'b000;
    localparam logic [2:0] STAGE_PRD   = 3'b001;
    localparam logic [2:0] STAGE_NEW   = 3'b010;
    localparam logic [2:0] STAGE_UPD   = 3'b100;

    localparam logic [2:0] STAGE_BUSY  = 3'b000;
    localparam logic [2:0] STAGE_READY = 3'b111;

    localparam logic [2:0] ERR_NONE     = 3'b000;
    localparam logic [2:0] ERR_BAD_TYPE = 3'b001;
    localparam logic [2:0] ERR_LM_RANGE = 3'b010;
    localparam logic [2:0] ERR_LM_FULL  = 3'b011;
    localparam logic [2:0] ERR_NO_BUSY  = 3'b100;
    localparam logic [2:0] ERR_TIMEOUT  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK     = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_RUN       = 3'd4,
        S_DONE      = 3'd5
    } sched_state_e;

    function automatic logic is_stage_code(input logic [2:0] code);
        return (code == STAGE_PRD) || (code == STAGE_NEW) || (code == STAGE_UPD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ekf_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ekf_cmd_fifo
// Purpose  : Synchronous command FIFO with combinational head; full is taken
//            from the registered count, so a pop frees a slot next cycle.
// Revision : 1.0  initial release
// ============================================================================
module ekf_cmd_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ekf_stage_sched.sv
`default_nettype none
// ============================================================================
// Module   : ekf_stage_sched
// Purpose  : Queues EKF step commands, validates them against the landmark
//            count and sequences one stage at a time through PE_config.
// Revision : 1.0  initial release
// ============================================================================
module ekf_stage_sched
    import ekf_pkg::*;
#(
    parameter int ROW_LEN   = 10,
    parameter int MAX_LM    = 1000,
    parameter int CMD_DEPTH = 4,
    parameter int TO_DW     = 16,
    parameter int BUSY_WAIT = 8,
    parameter int TIMEOUT   = 60000
) (
    input  logic               clk,
    input  logic               sys_rst_n,
    input  logic               cmd_val,
    output logic               cmd_rdy,
    input  logic [2:0]         cmd_type,
    input  logic [ROW_LEN-1:0] cmd_lm_id,
    output logic [2:0]         stage_val,
    input  logic [2:0]         stage_rdy,
    output logic [ROW_LEN-1:0] lm_id,
    output logic [ROW_LEN-1:0] landmark_num,
    output logic               busy,
    output logic               done,
    output logic [2:0]         done_stage,
    output logic               err,
    output logic [2:0]         err_code
);

    localparam logic [ROW_LEN-1:0] c_max_lm    = ROW_LEN'(MAX_LM);
    localparam logic [TO_DW-1:0]   c_busy_lim  = TO_DW'(BUSY_WAIT - 1);
    localparam logic [TO_DW-1:0]   c_run_lim   = TO_DW'(TIMEOUT - 1);

    sched_state_e         r_state;
    sched_state_e         w_state_nxt;
    logic [TO_DW-1:0]     r_wd_cnt;
    logic [2:0]           r_type;
    logic [ROW_LEN-1:0]   r_lm_id;
    logic [ROW_LEN-1:0]   r_lm_num;
    logic                 r_done;
    logic [2:0]           r_done_stage;
    logic                 r_err;
    logic [2:0]           r_err_code;
    logic                 w_err_set;
    logic [2:0]           w_err_val;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [ROW_LEN+2:0]   w_head;
    logic [2:0]           w_head_type;
    logic [ROW_LEN-1:0]   w_head_id;

    ekf_cmd_fifo #(
        .WIDTH (3 + ROW_LEN),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (sys_rst_n),
        .i_push  (cmd_val),
        .i_wdata ({cmd_type, cmd_lm_id}),
        .i_pop   (r_state == S_CHECK),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

    assign w_head_type = w_head[ROW_LEN +: 3];
    assign w_head_id   = w_head[ROW_LEN-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        w_err_val   = ERR_NONE;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                // Checks are prioritised: malformed type, then range, then capacity.
                if (!is_stage_code(w_head_type)) begin
                    w_err_set = 1'b1;
                    w_err_val = ERR_BAD_TYPE;
                end else if ((w_head_type == STAGE_UPD) && (w_head_id >= r_lm_num)) begin
                    w_err_set = 1'b1;
                    w_err_val = ERR_LM_RANGE;
                end else if ((w_head_type == STAGE_NEW) && (r_lm_num == c_max_lm)) begin
                    w_err_set = 1'b1;
                    w_err_val = ERR_LM_FULL;
                end
                w_state_nxt = w_err_set ? S_IDLE : S_ISSUE;
            end
            S_ISSUE: begin
                if (stage_rdy == STAGE_READY) w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (stage_rdy == STAGE_BUSY) begin
                    w_state_nxt = S_RUN;
                end else if (r_wd_cnt == c_busy_lim) begin
                    w_err_set   = 1'b1;
                    w_err_val   = ERR_NO_BUSY;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (stage_rdy == STAGE_READY) begin
                    w_state_nxt = S_DONE;
                end else if (r_wd_cnt == c_run_lim) begin
                    w_err_set   = 1'b1;
                    w_err_val   = ERR_TIMEOUT;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= S_IDLE;
            r_wd_cnt     <= '0;
            r_type       <= STAGE_IDLE;
            r_lm_id      <= '0;
            r_lm_num     <= '0;
            r_done       <= 1'b0;
            r_done_stage <= STAGE_IDLE;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
        end else begin
            r_state <= w_state_nxt;
            // Watchdog restarts on every state change and only runs while waiting on PE_config.
            if (r_state != w_state_nxt) begin
                r_wd_cnt <= '0;
            end else if ((r_state == S_WAIT_BUSY) || (r_state == S_RUN)) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if ((r_state == S_CHECK) && (w_state_nxt == S_ISSUE)) begin
                r_type  <= w_head_type;
                r_lm_id <= w_head_id;
            end
            r_done <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_DONE) r_done_stage <= r_type;
            r_err <= w_err_set;
            if (w_err_set) r_err_code <= w_err_val;
            if ((r_state == S_DONE) && (r_type == STAGE_NEW)) begin
                r_lm_num <= r_lm_num + 1'b1;
            end
        end
    end

    assign stage_val    = (r_state == S_ISSUE) ? r_type : STAGE_IDLE;
    assign cmd_rdy      = !w_fifo_full;
    assign busy         = (r_state != S_IDLE) || !w_fifo_empty;
    assign lm_id        = r_lm_id;
    assign landmark_num = r_lm_num;
    assign done         = r_done;
    assign done_stage   = r_done_stage;
    assign err          = r_err;
    assign err_code     = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_ekf_stage_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ekf_stage_sched
// Purpose  : Directed and randomized bench for ekf_stage_sched with an
//            emulated PE_config handshake and a command-outcome model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ekf_stage_sched;

    localparam int MAX_LM = 6;

    logic       clk = 1'b0;
    logic       sys_rst_n;
    logic       cmd_val;
    logic       cmd_rdy;
    logic [2:0] cmd_type;
    logic [9:0] cmd_lm_id;
    logic [2:0] stage_val;
    logic [2:0] stage_rdy;
    logic [9:0] lm_id;
    logic [9:0] landmark_num;
    logic       busy;
    logic       done;
    logic [2:0] done_stage;
    logic       err;
    logic [2:0] err_code;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_lm  = 0;

    always #5 clk = ~clk;

    ekf_stage_sched #(
        .ROW_LEN   (10),
        .MAX_LM    (MAX_LM),
        .CMD_DEPTH (4),
        .TO_DW     (16),
        .BUSY_WAIT (8),
        .TIMEOUT   (100)
    ) dut (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .cmd_val      (cmd_val),
        .cmd_rdy      (cmd_rdy),
        .cmd_type     (cmd_type),
        .cmd_lm_id    (cmd_lm_id),
        .stage_val    (stage_val),
        .stage_rdy    (stage_rdy),
        .lm_id        (lm_id),
        .landmark_num (landmark_num),
        .busy         (busy),
        .done         (done),
        .done_stage   (done_stage),
        .err          (err),
        .err_code     (err_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called on a negedge; the command is enqueued on the following posedge.
    task automatic push(input logic [2:0] t, input logic [9:0] id);
        cmd_val   = 1'b1;
        cmd_type  = t;
        cmd_lm_id = id;
        @(negedge clk);
        cmd_val   = 1'b0;
    endtask

    // Follows one queued command to its outcome, predicted from the command rules.
    task automatic complete(input logic [2:0] t, input logic [9:0] id,
                            input int acc, input int bsy, input int run, output int lat);
        int n;
        int exp_code;
        exp_code = 0;
        if (!(t == 3'b001 || t == 3'b010 || t == 3'b100)) exp_code = 1;
        else if (t == 3'b100 && int'(id) >= exp_lm)       exp_code = 2;
        else if (t == 3'b010 && exp_lm == MAX_LM)         exp_code = 3;
        stage_rdy = (acc > 0) ? 3'b000 : 3'b111;
        lat = 0;
        if (exp_code != 0) begin
            n = 0;
            while (err !== 1'b1 && n < 8) begin
                check("no_stage_on_err", stage_val, 3'b000);
                @(negedge clk);
                n++;
            end
            check("err_pulse", err, 1'b1);
            check("err_code", err_code, exp_code);
            check("lm_kept_on_err", landmark_num, exp_lm);
            @(negedge clk);
            check("err_one_cycle", err, 1'b0);
            check("err_code_hold", err_code, exp_code);
            return;
        end
        n = 0;
        while (stage_val === 3'b000 && n < 12) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        check("stage_val", stage_val, t);
        if (t == 3'b100) check("lm_id_issue", lm_id, id);
        repeat (acc) begin
            @(negedge clk);
            check("issue_hold", stage_val, t);
        end
        stage_rdy = 3'b111;
        @(negedge clk);
        check("stage_val_clear", stage_val, 3'b000);
        repeat (bsy) @(negedge clk);
        stage_rdy = 3'b000;
        repeat (run) begin
            @(negedge clk);
            check("no_issue_in_run", stage_val, 3'b000);
        end
        stage_rdy = 3'b111;
        n = 0;
        while (done !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        check("done_pulse", done, 1'b1);
        check("done_stage", done_stage, t);
        if (t == 3'b100) check("lm_id_stable", lm_id, id);
        if (t == 3'b010) exp_lm++;
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("landmark_num", landmark_num, exp_lm);
    endtask

    task automatic do_cmd(input logic [2:0] t, input logic [9:0] id,
                          input int acc, input int bsy, input int run);
        int lat;
        push(t, id);
        complete(t, id, acc, bsy, run, lat);
    endtask

    initial begin
        int lat;
        int n;
        logic [2:0] t;
        logic [9:0] id;
        int r;

        sys_rst_n = 1'b0;
        cmd_val   = 1'b0;
        cmd_type  = 3'b000;
        cmd_lm_id = '0;
        stage_rdy = 3'b111;
        repeat (3) @(negedge clk);
        sys_rst_n = 1'b1;
        @(negedge clk);
        check("rst_stage_val", stage_val, 3'b000);
        check("rst_lm_id", lm_id, 10'd0);
        check("rst_landmark_num", landmark_num, 10'd0);
        check("rst_done", done, 1'b0);
        check("rst_done_stage", done_stage, 3'b000);
        check("rst_err", err, 1'b0);
        check("rst_err_code", err_code, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_rdy", cmd_rdy, 1'b1);

        // PRD into an idle scheduler: three-edge latency, single-cycle request.
        push(3'b001, 10'd0);
        complete(3'b001, 10'd0, 0, 2, 18, lat);
        check("issue_latency", lat, 2);

        // Three NEW queued back to back.
        cmd_val  = 1'b1;
        cmd_type = 3'b010;
        cmd_lm_id = 10'd0;
        repeat (3) @(negedge clk);
        cmd_val = 1'b0;
        repeat (3) complete(3'b010, 10'd0, 0, 1, 5, lat);
        check("three_new", landmark_num, 10'd3);

        do_cmd(3'b100, 10'd3, 0, 1, 4);
        do_cmd(3'b100, 10'd2, 1, 2, 3);
        do_cmd(3'b011, 10'd0, 0, 0, 1);
        do_cmd(3'b010, 10'd0, 10, 0, 2);

        // PE_config never reports BUSY after accepting.
        push(3'b001, 10'd0);
        stage_rdy = 3'b111;
        n = 0;
        while (err !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("nobusy_err", err, 1'b1);
        check("nobusy_code", err_code, 3'b100);
        check("nobusy_stage_val", stage_val, 3'b000);

        // PE_config stays BUSY past the watchdog.
        @(negedge clk);
        push(3'b001, 10'd0);
        n = 0;
        while (stage_val === 3'b000 && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        stage_rdy = 3'b000;
        n = 0;
        while (err !== 1'b1 && n < 150) begin
            @(negedge clk);
            n++;
        end
        check("timeout_err", err, 1'b1);
        check("timeout_code", err_code, 3'b101);
        check("timeout_lm", landmark_num, exp_lm);
        stage_rdy = 3'b111;
        @(negedge clk);

        // Stall one stage in ISSUE and fill the queue behind it.
        stage_rdy = 3'b000;
        push(3'b001, 10'd0);
        n = 0;
        while (stage_val === 3'b000 && n < 10) begin
            @(negedge clk);
            n++;
        end
        cmd_val  = 1'b1;
        cmd_type = 3'b001;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("fifo_cmd_rdy", cmd_rdy, (i < 4) ? 1'b1 : 1'b0);
        end
        cmd_val = 1'b0;
        check("stall_stage_val", stage_val, 3'b001);
        repeat (5) complete(3'b001, 10'd0, 1, 0, 2, lat);
        check("drained_busy", busy, 1'b0);
        @(negedge clk);
        check("drained_no_issue", stage_val, 3'b000);

        // Reset while a stage is running.
        stage_rdy = 3'b111;
        push(3'b001, 10'd0);
        n = 0;
        while (stage_val === 3'b000 && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        stage_rdy = 3'b000;
        repeat (3) @(negedge clk);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_stage_val", stage_val, 3'b000);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_landmark", landmark_num, 10'd0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_err_code", err_code, 3'b000);
        check("mid_rst_cmd_rdy", cmd_rdy, 1'b1);
        exp_lm = 0;
        @(negedge clk);
        sys_rst_n = 1'b1;
        stage_rdy = 3'b111;
        @(negedge clk);
        do_cmd(3'b001, 10'd0, 0, 2, 6);

        // Randomized command stream against the model.
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      t = 3'b001;
            else if (r < 6) t = 3'b010;
            else if (r < 9) t = 3'b100;
            else            t = 3'($urandom_range(0, 7));
            id = 10'($urandom_range(0, 7));
            do_cmd(t, id, $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(1, 8));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
